// File: rtl/fetch_unit.sv
// +--------------------------------------------------------------------------+
// | fetch_unit                                                                 |
// | Instruction fetch stage: owns the PC, fetches from instruction memory and |
// | hands words to the IR stage. Optional macro FETCH_STATS_EN adds a        |
// | saturating fetch_count output.                                            |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module fetch_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int PC_STEP    = 4,
  parameter int RESET_PC   = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  ir_valid,
  input  logic                  ir_ready,
  output logic [DATA_WIDTH-1:0] ir_data,
  output logic [ADDR_WIDTH-1:0] ir_pc,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  halt,
`ifdef FETCH_STATS_EN
  output logic [15:0]           fetch_count,
`endif
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] c_pc_step  = ADDR_WIDTH'(PC_STEP);
  localparam logic [ADDR_WIDTH-1:0] c_reset_pc = ADDR_WIDTH'(RESET_PC);

  typedef enum logic [1:0] {
    ST_REQ    = 2'd0,
    ST_HOLD   = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_pc;

  assign imem_req  = (r_state == ST_REQ);
  assign imem_addr = r_pc;
  assign busy      = (r_state != ST_HALTED);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= ST_REQ;
      r_pc     <= c_reset_pc;
      ir_valid <= 1'b0;
      ir_data  <= '0;
      ir_pc    <= '0;
    end else if (redirect) begin
      // Redirect wins over everything: in-flight or held words are squashed.
      r_pc     <= redirect_pc;
      ir_valid <= 1'b0;
      r_state  <= halt ? ST_HALTED : ST_REQ;
    end else begin
      case (r_state)
        ST_REQ: begin
          if (imem_ready) begin
            ir_data  <= imem_rdata;
            ir_pc    <= r_pc;
            ir_valid <= 1'b1;
            r_pc     <= r_pc + c_pc_step;
            r_state  <= ST_HOLD;
          end else if (halt) begin
            r_state <= ST_HALTED;
          end
        end
        ST_HOLD: begin
          if (ir_ready) begin
            ir_valid <= 1'b0;
            r_state  <= halt ? ST_HALTED : ST_REQ;
          end
        end
        ST_HALTED: begin
          if (!halt) r_state <= ST_REQ;
        end
        default: r_state <= ST_REQ;
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  logic w_accept;
  assign w_accept = ir_valid && ir_ready && !redirect;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_count <= 16'h0000;
    end else if (w_accept && (fetch_count != 16'hFFFF)) begin
      fetch_count <= fetch_count + 16'h0001;
    end
  end
`endif

endmodule

`default_nettype wire
